// File: rtl/fc7_pkg.sv
// Shared types and constants for the fc7 fully-connected MAC engine.
package fc7_pkg;

  localparam int N_OUT     = 10;
  localparam int ACC_W_DEF = 24;
  localparam int PROD_W    = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    OUT   = 2'd3
  } state_t;

  typedef logic signed [ACC_W_DEF-1:0] score_t;

endpackage

// File: rtl/fc7_if.sv
// Result stream of fc7_mac: one class score per beat, valid/ready handshake.
interface fc7_if #(
  parameter int ACC_W = 24
);
  logic                    y_valid;
  logic                    y_ready;
  logic [3:0]              y_idx;
  logic signed [ACC_W-1:0] y_data;

  modport master (output y_valid, y_idx, y_data, input y_ready);
  modport slave  (input y_valid, y_idx, y_data, output y_ready);
endinterface

// File: rtl/fc7_lane.sv
// One signed multiply-accumulate lane: acc <= clr ? 0 : acc + x*w when enabled.
module fc7_lane
  import fc7_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_clr,
  input  logic                     i_en,
  input  logic signed [DATA_W-1:0] i_x,
  input  logic signed [COEF_W-1:0] i_w,
  output logic signed [ACC_W-1:0]  o_acc
);

  localparam int P_W = DATA_W + COEF_W;

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [P_W-1:0] p);
    return {{(ACC_W-P_W){p[P_W-1]}}, p};
  endfunction

  logic signed [P_W-1:0]   w_prod_p0;
  logic signed [ACC_W-1:0] r_acc_p1;

  assign w_prod_p0 = i_x * i_w;

  // stage p0 -> p1: accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc_p1 <= '0;
    end else if (i_clr) begin
      r_acc_p1 <= '0;
    end else if (i_en) begin
      r_acc_p1 <= r_acc_p1 + sext_prod(w_prod_p0);
    end
  end

  assign o_acc = r_acc_p1;

endmodule

// File: rtl/fc7_mac.sv
// fc7 layer engine: 84-input x 10-output dot products, results streamed via fc7_if.
// Optional running argmax output enabled by defining FC7_ARGMAX_EN.
module fc7_mac
  import fc7_pkg::*;
#(
  parameter int N_IN   = 84,
  parameter int ADDR_W = 7,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_start,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [ADDR_W-1:0]    o_x_raddr,
  input  logic signed [7:0]    i_x_rdata,
  output logic [ADDR_W-1:0]    o_w7_raddr,
  input  logic signed [7:0]    i_w7_1_rdata,
  input  logic signed [7:0]    i_w7_2_rdata,
  input  logic signed [7:0]    i_w7_3_rdata,
  input  logic signed [7:0]    i_w7_4_rdata,
  input  logic signed [7:0]    i_w7_5_rdata,
  input  logic signed [7:0]    i_w7_6_rdata,
  input  logic signed [7:0]    i_w7_7_rdata,
  input  logic signed [7:0]    i_w7_8_rdata,
  input  logic signed [7:0]    i_w7_9_rdata,
  input  logic signed [7:0]    i_w7_10_rdata,
  fc7_if.master                y_if
`ifdef FC7_ARGMAX_EN
  ,
  output logic [3:0]           o_class_idx,
  output logic                 o_class_vld
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);
  localparam logic [3:0]        LAST_IDX  = 4'(N_OUT - 1);

  state_t                  r_state, w_state_nxt;
  logic [ADDR_W-1:0]       r_addr;
  logic [3:0]              r_idx;
  logic                    r_done;
  logic                    r_vld_p1;
  logic                    w_start_acc;
  logic                    w_beat;
  logic                    w_last_beat;
  logic signed [7:0]       w_w[N_OUT];
  logic signed [ACC_W-1:0] w_acc[N_OUT];
  logic signed [ACC_W-1:0] w_y_data;

  assign w_w[0] = i_w7_1_rdata;
  assign w_w[1] = i_w7_2_rdata;
  assign w_w[2] = i_w7_3_rdata;
  assign w_w[3] = i_w7_4_rdata;
  assign w_w[4] = i_w7_5_rdata;
  assign w_w[5] = i_w7_6_rdata;
  assign w_w[6] = i_w7_7_rdata;
  assign w_w[7] = i_w7_8_rdata;
  assign w_w[8] = i_w7_9_rdata;
  assign w_w[9] = i_w7_10_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // a start sampled together with done is dropped so runs never overlap
  always_comb begin
    w_state_nxt = r_state;
    w_start_acc = 1'b0;
    w_beat      = 1'b0;
    w_last_beat = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start && !r_done) begin
          w_start_acc = 1'b1;
          w_state_nxt = FETCH;
        end
      end
      FETCH: begin
        if (r_addr == LAST_ADDR) w_state_nxt = DRAIN;
      end
      DRAIN: w_state_nxt = OUT;
      OUT: begin
        w_beat = y_if.y_ready;
        if (w_beat && r_idx == LAST_IDX) begin
          w_last_beat = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // stage p0: address issue; p1: read data returned and accumulated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_idx    <= '0;
      r_done   <= 1'b0;
      r_vld_p1 <= 1'b0;
    end else begin
      r_done   <= w_last_beat;
      r_vld_p1 <= (r_state == FETCH);
      if (w_start_acc || w_last_beat) r_addr <= '0;
      else if (r_state == FETCH && r_addr != LAST_ADDR) r_addr <= r_addr + 1'b1;
      if (w_last_beat)  r_idx <= '0;
      else if (w_beat)  r_idx <= r_idx + 1'b1;
    end
  end

  for (genvar g = 0; g < N_OUT; g++) begin : g_lane
    fc7_lane #(
      .DATA_W (8),
      .COEF_W (8),
      .ACC_W  (ACC_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_start_acc),
      .i_en  (r_vld_p1),
      .i_x   (i_x_rdata),
      .i_w   (w_w[g]),
      .o_acc (w_acc[g])
    );
  end

  always_comb begin
    w_y_data = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (r_idx == 4'(i)) w_y_data = w_acc[i];
    end
  end

  assign o_busy       = (r_state != IDLE);
  assign o_done       = r_done;
  assign o_x_raddr    = r_addr;
  assign o_w7_raddr   = r_addr;
  assign y_if.y_valid = (r_state == OUT);
  assign y_if.y_idx   = r_idx;
  assign y_if.y_data  = w_y_data;

`ifdef FC7_ARGMAX_EN
  logic signed [ACC_W-1:0] r_max;
  logic [3:0]              r_cls;

  // strict greater-than keeps the lowest index on ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max <= '0;
      r_cls <= '0;
    end else if (w_start_acc) begin
      r_max <= '0;
      r_cls <= '0;
    end else if (w_beat && (r_idx == 4'd0 || w_y_data > r_max)) begin
      r_max <= w_y_data;
      r_cls <= r_idx;
    end
  end

  assign o_class_idx = r_cls;
  assign o_class_vld = r_done;
`endif

endmodule

// File: tb/tb_fc7_mac.sv
// Scoreboard bench for fc7_mac: model dot products queued at start, popped per accepted beat.
module tb_fc7_mac;

  typedef struct {
    logic [3:0]         idx;
    logic signed [23:0] data;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              busy, done;
  logic [6:0]        x_raddr, w_raddr;
  logic signed [7:0] x_rdata;
  logic signed [7:0] w_rd[10];
  logic signed [7:0] xmem[128];
  logic signed [7:0] wmem[10][128];
  beat_t             sb[$];
  beat_t             mon_e;
  int                n_chk = 0;
  int                n_fail = 0;
  int                exp_cls;
  logic signed [23:0] exp_y[10];
`ifdef FC7_ARGMAX_EN
  logic [3:0]        class_idx;
  logic              class_vld;
`endif

  fc7_if #(.ACC_W(24)) y_if ();

  fc7_mac dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_start       (start),
    .o_busy        (busy),
    .o_done        (done),
    .o_x_raddr     (x_raddr),
    .i_x_rdata     (x_rdata),
    .o_w7_raddr    (w_raddr),
    .i_w7_1_rdata  (w_rd[0]),
    .i_w7_2_rdata  (w_rd[1]),
    .i_w7_3_rdata  (w_rd[2]),
    .i_w7_4_rdata  (w_rd[3]),
    .i_w7_5_rdata  (w_rd[4]),
    .i_w7_6_rdata  (w_rd[5]),
    .i_w7_7_rdata  (w_rd[6]),
    .i_w7_8_rdata  (w_rd[7]),
    .i_w7_9_rdata  (w_rd[8]),
    .i_w7_10_rdata (w_rd[9]),
    .y_if          (y_if)
`ifdef FC7_ARGMAX_EN
    ,
    .o_class_idx   (class_idx),
    .o_class_vld   (class_vld)
`endif
  );

  always #5 clk = ~clk;

  // synchronous activation RAM and weight ROM, one-cycle latency
  always @(posedge clk) begin
    x_rdata <= xmem[x_raddr];
    for (int i = 0; i < 10; i++) w_rd[i] <= wmem[i][w_raddr];
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && y_if.y_valid && y_if.y_ready) begin
      if (sb.size() == 0) begin
        chk("sb_extra_beat", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("y_idx", longint'(y_if.y_idx), longint'(mon_e.idx));
        chk("y_data", longint'(y_if.y_data), longint'(mon_e.data));
      end
    end
  end

  task automatic set_pat(input int mode);
    for (int k = 0; k < 128; k++) begin
      case (mode)
        0: xmem[k] = 8'sd1;
        1: xmem[k] = -8'sd128;
        2: xmem[k] = 8'(k - 42);
        4: xmem[k] = 8'sd1;
        default: xmem[k] = 8'($urandom_range(0, 255));
      endcase
      if (k >= 84) xmem[k] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 10; i++) begin
        case (mode)
          0: wmem[i][k] = 8'sd1;
          1: wmem[i][k] = -8'sd128;
          2: wmem[i][k] = 8'(i - 4);
          4: wmem[i][k] = (i == 2 || i == 7) ? 8'sd3 : 8'((i % 3) - 1);
          default: wmem[i][k] = 8'($urandom_range(0, 255));
        endcase
      end
    end
  endtask

  task automatic push_expected();
    int s;
    int best;
    exp_cls = 0;
    best = 0;
    for (int i = 0; i < 10; i++) begin
      s = 0;
      for (int k = 0; k < 84; k++) s += int'(xmem[k]) * int'(wmem[i][k]);
      exp_y[i] = 24'(s);
      sb.push_back('{idx: 4'(i), data: 24'(s)});
      if (i == 0 || s > best) begin
        best = s;
        exp_cls = i;
      end
    end
  endtask

  task automatic run(input bit bp, input bit spur);
    int n;
    int first_v;
    int stall;
    push_expected();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0; first_v = -1; stall = 0;
    while (!done && n < 400) begin
      @(posedge clk); n++; #1;
      start = spur && (n == 20 || n == 88);
      if (y_if.y_valid && first_v < 0) first_v = n;
      if (bp && y_if.y_valid && y_if.y_idx == 4'd3 && stall < 5) begin
        y_if.y_ready = 1'b0;
        stall++;
        chk("bp_hold_idx", longint'(y_if.y_idx), 3);
        chk("bp_hold_data", longint'(y_if.y_data), longint'(exp_y[3]));
      end else begin
        y_if.y_ready = 1'b1;
      end
    end
    if (n >= 400) begin
      chk("done_timeout", 1, 0);
    end else begin
      chk("first_valid_cycle", first_v, 85);
      chk("done_cycle", n, bp ? 100 : 95);
      chk("sb_empty_at_done", sb.size(), 0);
`ifdef FC7_ARGMAX_EN
      chk("class_vld", class_vld, 1);
      chk("class_idx", class_idx, exp_cls);
`endif
      start = spur;
      @(posedge clk); #1 start = 1'b0;
      chk("done_one_cycle", done, 0);
      chk("busy_after_done", busy, 0);
`ifdef FC7_ARGMAX_EN
      chk("class_idx_hold", class_idx, exp_cls);
`endif
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_valid"}, y_if.y_valid, 0);
    chk({tag, "_idx"}, y_if.y_idx, 0);
    chk({tag, "_data"}, y_if.y_data, 0);
    chk({tag, "_xaddr"}, x_raddr, 0);
    chk({tag, "_waddr"}, w_raddr, 0);
  endtask

  initial begin
    int n;
    start = 1'b0;
    y_if.y_ready = 1'b1;
    set_pat(0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;

    run(1'b0, 1'b0);
    set_pat(1);
    run(1'b0, 1'b0);
    set_pat(2);
    run(1'b1, 1'b0);
    set_pat(3);
    run(1'b0, 1'b1);

    set_pat(3);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    n = 0;
    while (x_raddr != 7'd40 && n < 100) begin
      @(posedge clk); n++; #1;
    end
    chk("abort_reach_addr40", x_raddr, 40);
    rst_n = 1'b0;
    #1 chk_zero("abort");
    @(posedge clk); #1 rst_n = 1'b1;
    set_pat(2);
    run(1'b0, 1'b0);

`ifdef FC7_ARGMAX_EN
    set_pat(4);
    run(1'b0, 1'b0);
    chk("argmax_tie_model", exp_cls, 2);
`endif

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
